imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 15'd0, meaning the first 32-bit word address written after start.
REQ-002 The block SHALL have parameter MAX_WORDS, default 32768, meaning the upper clamp applied to word_count.
REQ-003 The block SHALL have one clock and asynchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-004 start  in  1  begins a load when sampled high in IDLE.
REQ-005 word_count  in  16  number of words to load; sampled with start.
REQ-006 byte_valid  in  1  byte source has a byte on byte_data.
REQ-007 byte_data  in  8  byte from source (UART/SPI front end).
REQ-008 byte_ready  out  1  loader accepts byte_data this cycle.
REQ-009 mem_addr  out  15  word address to banked instruction memory; bit 14 selects bank.
REQ-010 mem_data_in  out  32  write data to memory.
REQ-011 mem_mask_wren  out  8  nibble write mask (two 16-bit halves x 4).
REQ-012 mem_wren  out  1  write strobe; mem_chip_sel  out  1  memory select.
REQ-013 mem_data_out  in  32  read data from memory, valid one cycle after a read cycle.
REQ-014 busy  out  1; done  out  1 (one-cycle pulse); error  out  1 (sticky readback mismatch).

Function
REQ-015 States SHALL be IDLE, COLLECT, WRITE, DONE, plus READ and CHECK when REQ-031 applies.
REQ-016 IDLE: start=1 latches remaining=min(word_count,MAX_WORDS), addr=BASE_ADDR, clears error; remaining 0 -> DONE, else -> COLLECT.
REQ-017 start while not IDLE SHALL be ignored.
REQ-018 COLLECT: byte_ready=1; byte accepted when byte_valid&byte_ready; k-th accepted byte (k=0..3) placed in word bits [8k+7:8k] (little-endian).
REQ-019 After the 4th accepted byte the next state SHALL be WRITE; byte_ready=0 in every state except COLLECT.
REQ-020 WRITE (exactly one cycle): mem_chip_sel=1, mem_wren=1, mem_mask_wren=8'hFF, mem_addr=addr, mem_data_in=assembled word.
REQ-021 Outside WRITE/READ, mem_chip_sel=0, mem_wren=0, mem_mask_wren=8'h00; mem_addr and mem_data_in hold last value.
REQ-022 Advance after a word: addr=addr+1 modulo 2^15 (32767 wraps to 0; 16383 -> 16384 crosses to bank 1 with no gap cycle), remaining decrements; remaining 0 -> DONE, else -> COLLECT.
REQ-023 Write latency SHALL be one cycle: mem_wren high on the cycle after the 4th byte is accepted.
REQ-024 DONE: done=1 for one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-025 Sustained throughput SHALL be one word per 5 cycles without readback, 7 with readback.

Reset
REQ-026 reset SHALL asynchronously force state IDLE, byte counter 0, assembled word 0, addr=BASE_ADDR, remaining 0.
REQ-027 Reset values: byte_ready=0, mem_addr=BASE_ADDR, mem_data_in=0, mem_mask_wren=0, mem_wren=0, mem_chip_sel=0, busy=0, done=0, error=0.
REQ-028 Reset mid-load SHALL discard any partial word and issue no further memory cycle.

Configuration
REQ-029 Macro LOADER_READBACK_EN SHALL control readback verification.
REQ-030 Without LOADER_READBACK_EN: WRITE advances directly per REQ-022; READ/CHECK absent; error tied 0.
REQ-031 With LOADER_READBACK_EN: WRITE -> READ (chip_sel=1, wren=0, mask=0, same addr) -> CHECK (mem_data_out compared with assembled word; mismatch sets error, sticky until next accepted start) -> advance per REQ-022.

Verification
REQ-032 start, word_count=2, bytes 01 02 03 04 05 06 07 08 -> writes 32'h04030201 @0 then 32'h08070605 @1, done pulse, busy low after.
REQ-033 BASE_ADDR=16383, word_count=2 -> writes at 16383 then 16384 (mem_addr[14] 0 then 1), consecutive words no gap.
REQ-034 BASE_ADDR=32767, word_count=2 -> second write at address 0.
REQ-035 word_count=0 -> done pulse one cycle after start, no mem_wren; start during busy -> ignored, count unchanged.
REQ-036 reset asserted after 2 bytes of a word -> all outputs at reset values immediately, no write; fresh start loads correctly.
REQ-037 LOADER_READBACK_EN, memory model corrupts bit 0 on read -> error=1 after CHECK, load still completes; error cleared by next start.

Source files
------------

// File: rtl/imem_loader_if.sv
// Control, byte-stream and memory-port signals of the instruction-memory loader.
// The loader drives the memory side through the master modport; the slave modport is the environment.
interface imem_loader_if;
  logic        start;
  logic [15:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [14:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [7:0]  mem_mask_wren;
  logic        mem_wren;
  logic        mem_chip_sel;
  logic [31:0] mem_data_out;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, word_count, byte_valid, byte_data, mem_data_out,
    output byte_ready, mem_addr, mem_data_in, mem_mask_wren, mem_wren,
           mem_chip_sel, busy, done, error
  );

  modport slave (
    output start, word_count, byte_valid, byte_data, mem_data_out,
    input  byte_ready, mem_addr, mem_data_in, mem_mask_wren, mem_wren,
           mem_chip_sel, busy, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to banked instruction memory.
// Define LOADER_READBACK_EN to read every word back and flag mismatches on error.
module imem_loader #(
  parameter logic [14:0] BASE_ADDR = 15'd0,
  parameter int          MAX_WORDS = 32768
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
`ifdef LOADER_READBACK_EN
  localparam logic [2:0] S_READ    = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
`endif
  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [14:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [14:0] maddr_q, maddr_d;
  logic [31:0] mdata_q, mdata_d;
  logic [15:0] wc_clamp;
`ifdef LOADER_READBACK_EN
  logic        err_q, err_d;
`endif

  assign wc_clamp = ({1'b0, bus.word_count} > MAXW) ? MAXW[15:0] : bus.word_count;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
`ifdef LOADER_READBACK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rem_d   = wc_clamp;
          addr_d  = BASE_ADDR;
          cnt_d   = 2'd0;
`ifdef LOADER_READBACK_EN
          err_d   = 1'b0;
`endif
          state_d = (wc_clamp == 16'd0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (bus.byte_valid) begin
          word_d[{cnt_q, 3'b000} +: 8] = bus.byte_data;
          cnt_d = cnt_q + 2'd1;
          // Latch the write beat here so the memory port holds it after the cycle.
          if (cnt_q == 2'd3) begin
            maddr_d = addr_q;
            mdata_d = word_d;
            state_d = S_WRITE;
          end
        end
      end
`ifdef LOADER_READBACK_EN
      S_WRITE: state_d = S_READ;
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        if (bus.mem_data_out != mdata_q) err_d = 1'b1;
        addr_d  = addr_q + 15'd1;
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? S_DONE : S_COLLECT;
      end
`else
      S_WRITE: begin
        addr_d  = addr_q + 15'd1;
        rem_d   = rem_q - 16'd1;
        state_d = (rem_q == 16'd1) ? S_DONE : S_COLLECT;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      word_q  <= 32'd0;
      addr_q  <= BASE_ADDR;
      rem_q   <= 16'd0;
      maddr_q <= BASE_ADDR;
      mdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
    end
  end

`ifdef LOADER_READBACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign bus.error        = err_q;
  assign bus.mem_chip_sel = (state_q == S_WRITE) || (state_q == S_READ);
`else
  assign bus.error        = 1'b0;
  assign bus.mem_chip_sel = (state_q == S_WRITE);
`endif

  assign bus.byte_ready    = (state_q == S_COLLECT);
  assign bus.mem_wren      = (state_q == S_WRITE);
  assign bus.mem_mask_wren = (state_q == S_WRITE) ? 8'hFF : 8'h00;
  assign bus.mem_addr      = maddr_q;
  assign bus.mem_data_in   = mdata_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Three loaders (bank-0 base, bank-crossing base, wrapping base) fed the same byte stream
// and checked against an address/byte arithmetic model plus a per-instance memory model.
module tb_imem_loader;
`ifdef LOADER_READBACK_EN
  localparam int P  = 7;
  localparam bit RB = 1'b1;
`else
  localparam int P  = 5;
  localparam bit RB = 1'b0;
`endif
  localparam int N = 3;

  logic clk, reset;
  logic start, bv, corrupt;
  logic [15:0] wc;
  logic [7:0]  bd;

  logic        rdy_a [N];
  logic        wren_a [N];
  logic        cs_a [N];
  logic        busy_a [N];
  logic        done_a [N];
  logic        err_a [N];
  logic [14:0] maddr_a [N];
  logic [31:0] mdin_a [N];
  logic [7:0]  mask_a [N];
  logic [31:0] rdata_a [N];

  logic [31:0] mem [N][0:32767];
  logic [14:0] waddr [N][0:255];
  logic [31:0] wdata [N][0:255];
  int wcnt [N] = '{default: 0};
  int dcnt [N] = '{default: 0};
  int acc  [N] = '{default: 0};
  int bad  [N] = '{default: 0};
  bit prev4 [N] = '{default: 1'b0};

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] bq [$];
  logic       e1 [N];

  imem_loader_if bus [N] ();

  function automatic logic [14:0] base(input int i);
    return (i == 0) ? 15'd0 : (i == 1) ? 15'd16383 : 15'd32767;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign bus[g].start        = start;
    assign bus[g].word_count   = wc;
    assign bus[g].byte_valid   = bv;
    assign bus[g].byte_data    = bd;
    assign bus[g].mem_data_out = rdata_a[g];
    assign rdy_a[g]   = bus[g].byte_ready;
    assign wren_a[g]  = bus[g].mem_wren;
    assign cs_a[g]    = bus[g].mem_chip_sel;
    assign busy_a[g]  = bus[g].busy;
    assign done_a[g]  = bus[g].done;
    assign err_a[g]   = bus[g].error;
    assign maddr_a[g] = bus[g].mem_addr;
    assign mdin_a[g]  = bus[g].mem_data_in;
    assign mask_a[g]  = bus[g].mem_mask_wren;
    imem_loader #(
      .BASE_ADDR((g == 0) ? 15'd0 : (g == 1) ? 15'd16383 : 15'd32767),
      .MAX_WORDS(4)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model and bus monitor: records writes, flags strobes not preceded by a 4th byte.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        acc[i]   <= 0;
        prev4[i] <= 1'b0;
      end else if (rdy_a[i] && bv) begin
        acc[i]   <= acc[i] + 1;
        prev4[i] <= ((acc[i] % 4) == 3);
      end else begin
        prev4[i] <= 1'b0;
      end
      if (cs_a[i] && wren_a[i]) begin
        mem[i][maddr_a[i]]     <= mdin_a[i];
        waddr[i][wcnt[i] % 256] <= maddr_a[i];
        wdata[i][wcnt[i] % 256] <= mdin_a[i];
        wcnt[i] <= wcnt[i] + 1;
        if (!prev4[i] || mask_a[i] != 8'hFF) bad[i] <= bad[i] + 1;
      end else if (!cs_a[i] && (wren_a[i] || mask_a[i] != 8'h00)) begin
        bad[i] <= bad[i] + 1;
      end
      if (cs_a[i] && !wren_a[i]) rdata_a[i] <= mem[i][maddr_a[i]] ^ {31'd0, corrupt};
      if (done_a[i]) dcnt[i] <= dcnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < N; i++) begin
      chk({tag, " byte_ready"}, 64'(rdy_a[i]), 64'd0);
      chk({tag, " mem_addr"},   64'(maddr_a[i]), 64'(base(i)));
      chk({tag, " mem_data_in"}, 64'(mdin_a[i]), 64'd0);
      chk({tag, " mask"},       64'(mask_a[i]), 64'd0);
      chk({tag, " wren"},       64'(wren_a[i]), 64'd0);
      chk({tag, " chip_sel"},   64'(cs_a[i]), 64'd0);
      chk({tag, " busy"},       64'(busy_a[i]), 64'd0);
      chk({tag, " done"},       64'(done_a[i]), 64'd0);
      chk({tag, " error"},      64'(err_a[i]), 64'd0);
    end
  endtask

  task automatic fill(input int nbytes);
    bq.delete();
    for (int k = 0; k < nbytes; k++) bq.push_back(8'($urandom));
  endtask

  // One load: wcount on the start cycle, nexp words expected, bytes from bq.
  task automatic run_load(input string tag, input int wcount, input int nexp,
                          input bit gappy, input bit poke, output int cyc);
    int w0 [N];
    int d0 [N];
    int idx;
    logic [31:0] ew;
    logic [14:0] ea;
    for (int i = 0; i < N; i++) begin w0[i] = wcnt[i]; d0[i] = dcnt[i]; end
    @(negedge clk);
    start = 1'b1;
    wc    = 16'(wcount);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    idx   = 0;
    for (int i = 0; i < N; i++) e1[i] = err_a[i];
    while (cyc < 400 && !done_a[0]) begin
      start = (poke && cyc == 3);
      wc    = poke ? 16'd3 : wc;
      if (idx < nexp * 4) begin
        bv = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
        bd = bq[idx];
        if (bv && rdy_a[0]) idx++;
      end else begin
        bv = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    bv    = 1'b0;
    chk({tag, " done reached"}, 64'(done_a[0]), 64'd1);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk({tag, " busy after"}, 64'(busy_a[i]), 64'd0);
      chk({tag, " done pulse width"}, 64'(done_a[i]), 64'd0);
      chk({tag, " done count"}, 64'(dcnt[i] - d0[i]), 64'd1);
      chk({tag, " write count"}, 64'(wcnt[i] - w0[i]), 64'(nexp));
      for (int j = 0; j < nexp; j++) begin
        ew = {bq[4*j+3], bq[4*j+2], bq[4*j+1], bq[4*j]};
        ea = 15'((int'(base(i)) + j) % 32768);
        chk({tag, " write addr"}, 64'(waddr[i][(w0[i] + j) % 256]), 64'(ea));
        chk({tag, " write data"}, 64'(wdata[i][(w0[i] + j) % 256]), 64'(ew));
        if (j == nexp - 1) begin
          chk({tag, " mem_addr hold"}, 64'(maddr_a[i]), 64'(ea));
          chk({tag, " mem_data_in hold"}, 64'(mdin_a[i]), 64'(ew));
        end
      end
    end
  endtask

  initial begin
    int cyc;
    int w0 [N];
    reset   = 1'b1;
    start   = 1'b0;
    wc      = 16'd0;
    bv      = 1'b0;
    bd      = 8'd0;
    corrupt = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    reset = 1'b0;

    // Directed two-word load, back-to-back bytes: exact cycle count.
    bq.delete();
    for (int k = 1; k <= 8; k++) bq.push_back(8'(k));
    run_load("two words", 2, 2, 1'b0, 1'b0, cyc);
    chk("two words cycles", 64'(cyc), 64'(P * 2 + 1));

    run_load("zero count", 0, 0, 1'b0, 1'b0, cyc);
    chk("zero count cycles", 64'(cyc), 64'd1);

    fill(8);
    run_load("start while busy", 2, 2, 1'b1, 1'b1, cyc);

    fill(16);
    run_load("clamped count", 6, 4, 1'b1, 1'b0, cyc);

    fill(4);
    run_load("single word timing", 1, 1, 1'b0, 1'b0, cyc);
    chk("single word cycles", 64'(cyc), 64'(P + 1));

    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 4);
      fill(n * 4);
      run_load("random load", n, n, 1'b1, 1'b0, cyc);
    end

    // Reset after two bytes of a word: no memory cycle, outputs back to reset values.
    fill(4);
    for (int i = 0; i < N; i++) w0[i] = wcnt[i];
    @(negedge clk);
    start = 1'b1;
    wc    = 16'd1;
    @(negedge clk);
    start = 1'b0;
    bv    = 1'b1;
    bd    = bq[0];
    @(negedge clk);
    bd    = bq[1];
    @(negedge clk);
    bv    = 1'b0;
    reset = 1'b1;
    #1;
    chk_reset("mid-load reset");
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) chk("mid-load reset writes", 64'(wcnt[i] - w0[i]), 64'd0);
    reset = 1'b0;
    fill(8);
    run_load("after reset", 2, 2, 1'b1, 1'b0, cyc);

    // Readback corrupted on bit 0: load completes, error only when readback is built in.
    corrupt = 1'b1;
    fill(8);
    run_load("corrupt readback", 2, 2, 1'b1, 1'b0, cyc);
    for (int i = 0; i < N; i++) chk("error after corrupt", 64'(err_a[i]), 64'(RB));
    corrupt = 1'b0;
    fill(4);
    run_load("error clear", 1, 1, 1'b1, 1'b0, cyc);
    for (int i = 0; i < N; i++) begin
      chk("error cleared on start", 64'(e1[i]), 64'd0);
      chk("error after clean load", 64'(err_a[i]), 64'd0);
      chk("bus protocol", 64'(bad[i]), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
